// File: rtl/lfsr_period_meter_pkg.sv
// Shared definitions for the LFSR period meter: FSM encoding and sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package lfsr_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } meter_state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Largest step count a measurement may reach before giving up (2^width).
  function automatic int max_cnt(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Measures the period of an LFSR by counting steps until a captured reference state recurs.
// Latency: done/period/flags update on the edge that samples the deciding step (visible next cycle).
// Backpressure: none; every step_valid in ARM/COUNT is consumed, start always wins and re-arms.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   start        - one-cycle pulse, (re)starts a measurement from any state
//   step_valid   - lfsr_state holds a freshly shifted value this cycle
//   lfsr_state   - LFSR register contents
//   busy         - measurement in progress (ARM or COUNT)
//   done         - result valid, held until the next start
//   period       - measured period, 0 on lockup or timeout
//   maximal      - done and period == 2^DATAWITH - 1
//   lockup       - all-zero state seen during the measurement
//   timeout      - reference state did not recur within 2^DATAWITH steps
module lfsr_period_meter
  import lfsr_period_meter_pkg::*;
#(
  parameter int DATAWITH = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                step_valid,
  input  logic [DATAWITH-1:0] lfsr_state,
  output logic                busy,
  output logic                done,
  output logic [DATAWITH:0]   period,
  output logic                maximal,
  output logic                lockup,
  output logic                timeout
);

  // Counter width is exactly what holds 2^DATAWITH, i.e. DATAWITH+1 bits.
  localparam int CNT_W = clog2(max_cnt(DATAWITH) + 1);
  localparam logic [CNT_W-1:0] MAXCNT = CNT_W'(max_cnt(DATAWITH));
  localparam logic [CNT_W-1:0] MAXLEN = CNT_W'(max_cnt(DATAWITH) - 1);

  meter_state_t        state_q, state_d;
  logic [DATAWITH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                lockup_q, lockup_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, done_q;
  logic [CNT_W-1:0]    cnt_next;

  assign cnt_next = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    lockup_d  = lockup_q;
    timeout_d = timeout_q;

    if (start) begin
      // Any step arriving with start is dropped; the next step becomes the reference.
      state_d   = ARM;
      period_d  = '0;
      lockup_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ARM: begin
          if (step_valid) begin
            ref_d = lfsr_state;
            cnt_d = '0;
            if (lfsr_state == '0) begin
              lockup_d = 1'b1;
              period_d = '0;
              state_d  = DONE;
            end else begin
              state_d = COUNT;
            end
          end
        end
        COUNT: begin
          if (step_valid) begin
            // Order matters: a recurrence on the 2^N-th step is still a valid period.
            if (lfsr_state == ref_q) begin
              period_d = cnt_next;
              state_d  = DONE;
            end else if (lfsr_state == '0) begin
              lockup_d = 1'b1;
              period_d = '0;
              state_d  = DONE;
            end else if (cnt_next == MAXCNT) begin
              timeout_d = 1'b1;
              period_d  = '0;
              state_d   = DONE;
            end else begin
              cnt_d = cnt_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ref_q     <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      lockup_q  <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      lockup_q  <= lockup_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d == ARM) || (state_d == COUNT);
      done_q    <= (state_d == DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign period  = period_q;
  assign lockup  = lockup_q;
  assign timeout = timeout_q;
  assign maximal = done_q && (period_q == MAXLEN);

endmodule

// File: tb/tb_lfsr_period_meter.sv
// Randomized self-checking bench for lfsr_period_meter at DATAWITH=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_lfsr_period_meter;

  localparam int W    = 4;
  localparam int MAXC = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         step_valid;
  logic [W-1:0] lfsr_state;
  logic         busy;
  logic         done;
  logic [W:0]   period;
  logic         maximal;
  logic         lockup;
  logic         timeout;

  lfsr_period_meter #(.DATAWITH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step_valid (step_valid),
    .lfsr_state (lfsr_state),
    .busy       (busy),
    .done       (done),
    .period     (period),
    .maximal    (maximal),
    .lockup     (lockup),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus sequence for one measurement and the model's verdict on it.
  logic [W-1:0] seq[$];
  int m_steps;
  int m_period;
  int m_lock;
  int m_tout;

  // Reference model over the whole list: first entry is the reference state,
  // walk forward until it reappears, a zero shows up, or 2^W steps elapse.
  function automatic void model();
    logic [W-1:0] r;
    m_steps = 0; m_period = 0; m_lock = 0; m_tout = 0;
    r = seq[0];
    if (r == 0) begin
      m_steps = 1; m_lock = 1;
      return;
    end
    for (int i = 1; i < seq.size(); i++) begin
      if (seq[i] == r) begin
        m_steps = i + 1; m_period = i; return;
      end
      if (seq[i] == 0) begin
        m_steps = i + 1; m_lock = 1; return;
      end
      if (i == MAXC) begin
        m_steps = i + 1; m_tout = 1; return;
      end
    end
  endfunction

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  task automatic build_max(input logic [W-1:0] seed, input int len);
    logic [W-1:0] s;
    seq.delete();
    s = seed;
    for (int i = 0; i < len; i++) begin
      seq.push_back(s);
      s = lfsr_next(s);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step(input logic [W-1:0] v, input int gap);
    repeat (gap) @(negedge clk);
    step_valid = 1'b1;
    lfsr_state = v;
    @(negedge clk);
    step_valid = 1'b0;
    lfsr_state = W'($urandom);
  endtask

  task automatic run_seq(input int max_gap, input string tag);
    logic [W:0] held;
    model();
    if (m_steps == 0) begin
      check({tag, "_model_end"}, 0, 1);
      return;
    end
    for (int i = 0; i < m_steps; i++) begin
      if (i == m_steps - 1) begin
        check({tag, "_busy_pre"}, int'(busy), 1);
        check({tag, "_done_pre"}, int'(done), 0);
      end
      step(seq[i], $urandom_range(0, max_gap));
    end
    check({tag, "_done"},    int'(done),    1);
    check({tag, "_busy"},    int'(busy),    0);
    check({tag, "_period"},  int'(period),  m_period);
    check({tag, "_lockup"},  int'(lockup),  m_lock);
    check({tag, "_timeout"}, int'(timeout), m_tout);
    check({tag, "_maximal"}, int'(maximal),
          (m_period == MAXC - 1 && m_lock == 0 && m_tout == 0) ? 1 : 0);
    // Steps after the verdict must not disturb the result.
    held = period;
    step(W'($urandom), 0);
    check({tag, "_hold_done"},   int'(done),   1);
    check({tag, "_hold_period"}, int'(period), int'(held));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] cyc[$];
    logic [W-1:0] seed;
    int kind;
    int clen;

    rst_n = 1'b0; start = 1'b0; step_valid = 1'b0; lfsr_state = '0;
    #13;
    check("rst_busy",    int'(busy),    0);
    check("rst_done",    int'(done),    0);
    check("rst_period",  int'(period),  0);
    check("rst_maximal", int'(maximal), 0);
    check("rst_lockup",  int'(lockup),  0);
    check("rst_timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Steps in IDLE are ignored.
    step(4'd5, 0);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);

    // 1: maximal sequence from 1000.
    pulse_start();
    check("start_busy", int'(busy), 1);
    check("start_done", int'(done), 0);
    build_max(4'b1000, 18);
    run_seq(0, "max");
    check("max_const_period", int'(period), 15);

    // 2: zero on the first step.
    pulse_start();
    check("restart_clears_done", int'(done), 0);
    check("restart_clears_max",  int'(maximal), 0);
    seq.delete();
    seq.push_back(4'd0);
    for (int i = 0; i < 17; i++) seq.push_back(W'($urandom_range(1, 15)));
    run_seq(0, "lock0");
    check("lock0_const", int'(lockup), 1);

    // 3: six-state cycle.
    pulse_start();
    cyc = '{4'd1, 4'd3, 4'd7, 4'd14, 4'd12, 4'd8};
    seq.delete();
    for (int i = 0; i < 18; i++) seq.push_back(cyc[i % 6]);
    run_seq(0, "cyc6");
    check("cyc6_const_period", int'(period), 6);

    // 4: reference never returns.
    pulse_start();
    seq.delete();
    seq.push_back(4'd1);
    for (int i = 0; i < 17; i++) seq.push_back(4'd3);
    run_seq(0, "tout");
    check("tout_const", int'(timeout), 1);

    // 5a: start collides with the fifth step of a running count.
    pulse_start();
    build_max(4'b1000, 5);
    for (int i = 0; i < 4; i++) step(seq[i], 0);
    start = 1'b1; step_valid = 1'b1; lfsr_state = seq[4];
    @(negedge clk);
    start = 1'b0; step_valid = 1'b0;
    check("abort_busy", int'(busy), 1);
    check("abort_done", int'(done), 0);
    build_max(4'b0110, 18);
    run_seq(1, "rearm");
    check("rearm_const_period", int'(period), 15);

    // 5b: asynchronous reset in the middle of a count.
    pulse_start();
    build_max(4'b1000, 3);
    for (int i = 0; i < 3; i++) step(seq[i], 0);
    check("mid_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",    int'(busy),    0);
    check("arst_done",    int'(done),    0);
    check("arst_period",  int'(period),  0);
    check("arst_lockup",  int'(lockup),  0);
    check("arst_timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'd9, 0);
    check("arst_idle_busy", int'(busy), 0);

    // 6: gapped maximal sequence, then randomized mixes.
    pulse_start();
    build_max(4'b1000, 18);
    run_seq(3, "gap");
    check("gap_const_max", int'(maximal), 1);

    for (int r = 0; r < 12; r++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        seed = W'($urandom_range(1, 15));
        build_max(seed, 18);
      end else if (kind == 1) begin
        seq.delete();
        for (int i = 0; i < 18; i++) seq.push_back(W'($urandom_range(0, 15)));
      end else begin
        clen = $urandom_range(1, 7);
        cyc.delete();
        for (int i = 0; i < clen; i++) cyc.push_back(W'($urandom_range(1, 15)));
        seq.delete();
        for (int i = 0; i < 18; i++) seq.push_back(cyc[i % clen]);
      end
      pulse_start();
      run_seq(3, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_period_meter.md
Name: lfsr_period_meter

Overview:
Downstream observer for the LFSR stage. Samples the LFSR state on each step strobe, captures a reference state, and counts steps until that state recurs. Reports the period, and flags maximal-length sequences, all-zero lockup, and non-returning (transient) sequences. Used on the board and in simulation to qualify user-loaded feedback polynomials.

Parameters:
DATAWITH, 10, LFSR state width; must match the LFSR stage (valid range 2..16).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; (re)starts a measurement from any state.
step_valid  input  1  high for one cycle when lfsr_state holds a newly shifted value (integration delays the LFSR's en by one cycle).
lfsr_state  input  DATAWITH  LFSR register contents.
busy  output  1  high in ARM or COUNT.
done  output  1  high in DONE until the next start.
period  output  DATAWITH+1  measured period; valid when done=1; 0 on lockup or timeout.
maximal  output  1  done and period == 2^DATAWITH - 1.
lockup  output  1  all-zero state observed during the measurement.
timeout  output  1  reference state did not recur within 2^DATAWITH steps.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. In reset: state=IDLE, every output 0, internal ref and cnt 0.
- State machine:
  - IDLE: on start -> ARM; clear period, maximal, lockup and timeout.
  - ARM: on step_valid, ref <= lfsr_state and cnt <= 0, then -> COUNT. If lfsr_state == 0: lockup=1, period=0, -> DONE.
  - COUNT: on step_valid, the next count is n = cnt+1.
    - If lfsr_state == ref: period <= n, -> DONE.
    - Else if lfsr_state == 0: lockup=1, period=0, -> DONE.
    - Else if n == 2^DATAWITH: timeout=1, period=0, -> DONE.
    - Otherwise cnt <= n.
  - DONE: outputs hold; on start -> ARM with flags cleared.
- Precedence:
  - start beats step_valid in the same cycle, in every state. ARM is entered and that step is ignored.
  - start during ARM or COUNT aborts silently and re-arms. done is not raised.
  - A match with ref beats timeout on the same step.
- Timing:
  - done, period and the flags update on the clock edge that samples the deciding step. They are visible the cycle after that step.
  - maximal is combinational from done and period. All other outputs are registered.
- Widths:
  - cnt and period are DATAWITH+1 bits; 2^DATAWITH fits without wrap.
  - The compare uses the full width. No truncation.
- Inputs:
  - step_valid outside ARM or COUNT is ignored.
  - lfsr_state is ignored when step_valid=0.
- Reset mid-measurement returns to IDLE immediately. No partial result is kept.

Decomposition:
- Shared package/header holds:
  - the FSM state encodings (IDLE=2'd0, ARM=2'd1, COUNT=2'd2, DONE=2'd3);
  - a clog2 helper;
  - localparam MAXCNT = 2^DATAWITH.
- No sub-module; the FSM, counter and comparator are a single flat block.

Test Plan:
1. DATAWITH=4; bench model drives a maximal 4-bit sequence seeded 4'b1000, start, then 16 step_valids -> done=1 after the 16th, period=15, maximal=1, lockup=0, timeout=0.
2. lfsr_state=4'b0000 at the first step after start -> done=1 one cycle later, lockup=1, period=0, maximal=0.
3. Sequence with a 6-state cycle (1,3,7,14,12,8, repeat) -> period=6, maximal=0, done after 7 steps.
4. First step 4'b0001, then constant 4'b0011 on every step -> timeout=1 after step 17 (cnt reaches 16), period=0.
5. start pulse at step 5 of a count, in the same cycle as step_valid -> that step is ignored, re-arm, next step becomes ref; a full-cycle sequence still yields period=15. rst_n low mid-count -> all outputs 0 immediately (asynchronously).
6. Gaps in step_valid (random 0-3 idle cycles between steps) on the case-1 sequence -> same result: period=15, maximal=1.
